// File: rtl/and_or_pkg.sv
// Shared definitions for the AND-OR event path: debounce state encoding and
// default sizing of the event counter stage.
package and_or_pkg;

  typedef enum logic [1:0] {
    LOW    = 2'd0,
    CHK_HI = 2'd1,
    HIGH   = 2'd2,
    CHK_LO = 2'd3
  } db_state_t;

  localparam int unsigned DEF_HOLD  = 3;
  localparam int unsigned DEF_CNT_W = 8;

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer for a single asynchronous input bit.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/and_or_event_counter.sv
// Debounces the synchronized AND-OR output, emits rise/fall pulses on accepted
// level changes and keeps a saturating count of accepted rising edges.
module and_or_event_counter
  import and_or_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned HOLD  = DEF_HOLD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             y,
  input  logic             clr,
  output logic             rise,
  output logic             fall,
  output logic             y_stable,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [3:0]       HOLD_LAST = 4'(HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic             y_s2;
  db_state_t        state, state_nxt;
  logic [3:0]       hcnt, hcnt_nxt;
  logic             rise_nxt, fall_nxt;
  logic [CNT_W-1:0] count_nxt;

  sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (y),
    .q   (y_s2)
  );

  // hcnt counts consecutive samples of the candidate level, entry sample included.
  always_comb begin
    state_nxt = state;
    hcnt_nxt  = hcnt;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      LOW: begin
        if (y_s2) begin
          if (HOLD == 1) begin
            state_nxt = HIGH;
            rise_nxt  = 1'b1;
            hcnt_nxt  = '0;
          end else begin
            state_nxt = CHK_HI;
            hcnt_nxt  = 4'd1;
          end
        end
      end
      CHK_HI: begin
        if (!y_s2) begin
          state_nxt = LOW;
          hcnt_nxt  = '0;
        end else if (hcnt == HOLD_LAST) begin
          state_nxt = HIGH;
          rise_nxt  = 1'b1;
          hcnt_nxt  = '0;
        end else begin
          hcnt_nxt = hcnt + 4'd1;
        end
      end
      HIGH: begin
        if (!y_s2) begin
          if (HOLD == 1) begin
            state_nxt = LOW;
            fall_nxt  = 1'b1;
            hcnt_nxt  = '0;
          end else begin
            state_nxt = CHK_LO;
            hcnt_nxt  = 4'd1;
          end
        end
      end
      CHK_LO: begin
        if (y_s2) begin
          state_nxt = HIGH;
          hcnt_nxt  = '0;
        end else if (hcnt == HOLD_LAST) begin
          state_nxt = LOW;
          fall_nxt  = 1'b1;
          hcnt_nxt  = '0;
        end else begin
          hcnt_nxt = hcnt + 4'd1;
        end
      end
      default: begin
        state_nxt = LOW;
        hcnt_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    count_nxt = count;
    if (clr)
      count_nxt = '0;
    else if (rise_nxt && (count != CNT_MAX))
      count_nxt = count + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LOW;
      hcnt     <= '0;
      rise     <= 1'b0;
      fall     <= 1'b0;
      y_stable <= 1'b0;
      count    <= '0;
      sat      <= 1'b0;
    end else begin
      state    <= state_nxt;
      hcnt     <= hcnt_nxt;
      rise     <= rise_nxt;
      fall     <= fall_nxt;
      y_stable <= (state_nxt == HIGH) || (state_nxt == CHK_LO);
      count    <= count_nxt;
      sat      <= (count_nxt == CNT_MAX);
    end
  end

endmodule

// File: tb/tb_and_or_event_counter.sv
// Drives an AND-OR block into two counter instances (8-bit and 2-bit count)
// and checks them against a sample-window debounce model every cycle.
module tb_and_or_event_counter;
  import and_or_pkg::*;

  localparam int unsigned HOLD    = DEF_HOLD;
  localparam int unsigned W8      = DEF_CNT_W;
  localparam int unsigned MAX8    = (1 << W8) - 1;
  localparam int unsigned MAX2    = 3;

  logic clk = 1'b0;
  logic rst, clr, a, b, c, d;
  logic y;
  logic rise_a, fall_a, ys_a, sat_a;
  logic [W8-1:0] count_a;
  logic rise_b, fall_b, ys_b, sat_b;
  logic [1:0] count_b;

  assign y = (a & b) | (c & d);

  always #5 clk = ~clk;

  and_or_event_counter #(.CNT_W(W8), .HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .y(y), .clr(clr),
    .rise(rise_a), .fall(fall_a), .y_stable(ys_a), .count(count_a), .sat(sat_a)
  );

  and_or_event_counter #(.CNT_W(2), .HOLD(HOLD)) dut2 (
    .clk(clk), .rst(rst), .y(y), .clr(clr),
    .rise(rise_b), .fall(fall_b), .y_stable(ys_b), .count(count_b), .sat(sat_b)
  );

  int total = 0;
  int bad   = 0;

  bit yq[$];
  bit win[$];
  bit m_stable, m_rise, m_fall;
  int unsigned m_cnt8, m_cnt2;
  int unsigned rises_seen, falls_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // A level change is accepted once the last HOLD synchronized samples all
  // disagree with the current stable level; y reaches the FSM two edges late.
  task automatic model_edge();
    bit s;
    bit all_diff;
    if (rst) begin
      yq.delete();
      yq.push_back(1'b0);
      yq.push_back(1'b0);
      win.delete();
      m_stable = 1'b0;
      m_rise   = 1'b0;
      m_fall   = 1'b0;
      m_cnt8   = 0;
      m_cnt2   = 0;
    end else begin
      s = yq[$-1];
      yq.push_back(y);
      if (yq.size() > 4) void'(yq.pop_front());
      win.push_back(s);
      if (win.size() > HOLD) void'(win.pop_front());
      all_diff = (win.size() == HOLD);
      foreach (win[i]) if (win[i] == m_stable) all_diff = 1'b0;
      m_rise = all_diff && !m_stable;
      m_fall = all_diff && m_stable;
      if (all_diff) m_stable = !m_stable;
      if (clr) begin
        m_cnt8 = 0;
        m_cnt2 = 0;
      end else if (m_rise) begin
        if (m_cnt8 < MAX8) m_cnt8++;
        if (m_cnt2 < MAX2) m_cnt2++;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("rise8",   32'(rise_a),  32'(m_rise));
    chk("fall8",   32'(fall_a),  32'(m_fall));
    chk("stable8", 32'(ys_a),    32'(m_stable));
    chk("count8",  32'(count_a), 32'(m_cnt8));
    chk("sat8",    32'(sat_a),   32'(m_cnt8 == MAX8));
    chk("rise2",   32'(rise_b),  32'(m_rise));
    chk("fall2",   32'(fall_b),  32'(m_fall));
    chk("stable2", 32'(ys_b),    32'(m_stable));
    chk("count2",  32'(count_b), 32'(m_cnt2));
    chk("sat2",    32'(sat_b),   32'(m_cnt2 == MAX2));
    chk("rise_fall_excl", 32'(rise_a & fall_a), 32'(0));
    if (rise_a === 1'b1) rises_seen++;
    if (fall_a === 1'b1) falls_seen++;
  endtask

  task automatic run(input int unsigned n);
    repeat (n) cyc();
  endtask

  task automatic set_abcd(input logic [3:0] v);
    {a, b, c, d} = v;
  endtask

  task automatic set_y(input bit v);
    set_abcd(v ? 4'b1111 : 4'b0000);
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
  endtask

  task automatic clean_pulse();
    set_y(1'b1);
    run(HOLD + 4);
    set_y(1'b0);
    run(HOLD + 5);
  endtask

  initial begin
    int unsigned lat;
    logic [3:0] pats [4];
    pats[0] = 4'b0000; pats[1] = 4'b0110; pats[2] = 4'b1001; pats[3] = 4'b1111;

    // Reset with y high, then first rise latency
    rst = 1'b1;
    clr = 1'b0;
    set_y(1'b1);
    run(2);
    chk("rst_rise",  32'(rise_a),   32'(0));
    chk("rst_count", 32'(count_a),  32'(0));
    chk("rst_stable", 32'(ys_a),    32'(0));
    chk("rst_sat",   32'(sat_a),    32'(0));
    rst = 1'b0;
    rises_seen = 0;
    lat = 0;
    for (int unsigned i = 1; i <= 12; i++) begin
      cyc();
      if (rise_a === 1'b1 && lat == 0) lat = i;
    end
    chk("rise_latency", lat, HOLD + 2);
    chk("rise_once", rises_seen, 1);
    chk("count_first", 32'(count_a), 32'(1));

    // Glitch shorter than HOLD is rejected
    set_y(1'b0);
    run(10);
    clr_pulse();
    rises_seen = 0;
    set_y(1'b1);
    run(HOLD - 1);
    set_y(1'b0);
    run(10);
    chk("glitch_rise", rises_seen, 0);
    chk("glitch_stable", 32'(ys_a), 32'(0));
    chk("glitch_count", 32'(count_a), 32'(0));

    // Exactly HOLD cycles is accepted
    set_y(1'b1);
    run(HOLD);
    set_y(1'b0);
    run(12);
    chk("minwidth_rise", rises_seen, 1);

    // Patterns through the AND-OR block
    clr_pulse();
    rises_seen = 0;
    falls_seen = 0;
    foreach (pats[i]) begin
      set_abcd(pats[i]);
      run(20);
    end
    chk("andor_rises", rises_seen, 1);
    chk("andor_count", 32'(count_a), 32'(1));
    chk("andor_falls_pre", falls_seen, 0);
    set_abcd(4'b0000);
    run(20);
    chk("andor_falls", falls_seen, 1);

    // Saturation of the 2-bit counter
    clr_pulse();
    for (int unsigned p = 0; p < 5; p++) begin
      set_y(1'b1);
      run(HOLD + 4);
      chk("sat_count2", 32'(count_b), (p + 1 < 3) ? p + 1 : 3);
      chk("sat_flag2", 32'(sat_b), 32'(p >= 2));
      set_y(1'b0);
      run(HOLD + 5);
    end

    // clr at the same edge that raises rise
    clr_pulse();
    clean_pulse();
    clean_pulse();
    chk("coll_pre", 32'(count_a), 32'(2));
    set_y(1'b1);
    run(HOLD + 1);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("coll_rise", 32'(rise_a), 32'(1));
    chk("coll_count", 32'(count_a), 32'(0));
    set_y(1'b0);
    run(HOLD + 5);
    clean_pulse();
    chk("coll_next", 32'(count_a), 32'(1));

    // Reset while checking for high
    set_y(1'b1);
    run(3);
    rst = 1'b1;
    set_y(1'b0);
    cyc();
    rst = 1'b0;
    rises_seen = 0;
    run(10);
    chk("rstmid_rise", rises_seen, 0);
    chk("rstmid_count", 32'(count_a), 32'(0));
    chk("rstmid_stable", 32'(ys_a), 32'(0));

    // Random AND-OR inputs with occasional clears
    for (int unsigned i = 0; i < 80; i++) begin
      set_abcd(4'($urandom_range(0, 15)));
      clr = ($urandom_range(0, 15) == 0);
      run($urandom_range(1, 6));
    end
    clr = 1'b0;
    run(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
